punc_control: RTL
=================

# punc_control

Control FSM for the PUnC LC3 processor. It sequences the datapath through fetch, decode and execute. Each cycle it drives the datapath's write enables, its 3-bit one-hot state input and its LDI phase strobes, all decoded from the 4-bit `op_code` the datapath returns. It sits beside the datapath inside the processor top and is the only source of every `CNTRL_*` signal.

## Interface
- No parameters.
- `clk`  in  1  processor clock.
- `rst`  in  1  synchronous, active-high reset.
- `op_code`  in  4  `ir[15:12]` from the datapath; valid in EXEC/EXEC2.
- `CNTRL_state`  out  3  datapath phase.
  - FETCH = 3'b001, DECODE = 3'b010, EXEC and EXEC2 = 3'b100, HALT = 3'b000.
- `CNTRL_ir_w_en`  out  1  IR capture.
- `CNTRL_pc_w_en`  out  1  PC update.
- `CNTRL_regfiles_w_en`  out  1  register-file write.
- `CNTRL_memory_w_en`  out  1  memory write.
- `CNTRL_status_w_en`  out  1  NZP condition-code update.
- `CNTRL_OC_LDI_first`  out  1  LDI indirect-address phase.
- `CNTRL_OC_LDI_second`  out  1  LDI data phase.
- `halted`  out  1  high while in HALT.

## Operation
- Internal states: FETCH, DECODE, EXEC, EXEC2, HALT. State is registered; all outputs are decoded combinationally from state and `op_code`.
- FETCH:
  - `CNTRL_state`=001.
  - All enables 0.
  - Next state DECODE.
- DECODE:
  - `CNTRL_state`=010.
  - `CNTRL_ir_w_en`=1, `CNTRL_pc_w_en`=1 (PC+1).
  - Next state EXEC.
- EXEC: `CNTRL_state`=100. Enables by opcode:
  - ADD 0001, AND 0101, NOT 1001, LD 0010, LDR 0110: `CNTRL_regfiles_w_en`=1, `CNTRL_status_w_en`=1.
  - LEA 1110: `CNTRL_regfiles_w_en`=1 only.
  - JSR 0100: `CNTRL_regfiles_w_en`=1 (R7 link), `CNTRL_pc_w_en`=1.
  - BR 0000, JMP 1100: `CNTRL_pc_w_en`=1. The branch condition is resolved in the datapath.
  - ST 0011, STR 0111, STI 1011: `CNTRL_memory_w_en`=1.
  - LDI 1010: `CNTRL_OC_LDI_first`=1, all write enables 0; next state EXEC2.
  - TRAP 1111: no enables; next state HALT.
  - RTI 1000, reserved 1101: NOP; no enables.
  - Every opcode other than LDI and TRAP: next state FETCH.
- EXEC2 (LDI only):
  - `CNTRL_state`=100.
  - `CNTRL_OC_LDI_second`=1, `CNTRL_regfiles_w_en`=1, `CNTRL_status_w_en`=1.
  - Next state FETCH.
- HALT:
  - `CNTRL_state`=000, `halted`=1, all enables 0.
  - Remains in HALT until `rst`.
- At most one of `CNTRL_OC_LDI_first` and `CNTRL_OC_LDI_second` is high in any cycle.
- `CNTRL_memory_w_en` and `CNTRL_regfiles_w_en` are never both high.

## Timing
- Reset:
  - `rst` sampled high at a rising edge puts the state in FETCH at that edge, from any state including HALT, EXEC or EXEC2 mid-LDI.
  - While `rst` is high, all enables are forced to 0 and `CNTRL_state`=001, `halted`=0.
- The first FETCH completes on the first edge with `rst` low.
- Latency:
  - 3 cycles per instruction (FETCH, DECODE, EXEC).
  - LDI takes 4 cycles.
  - TRAP reaches HALT 3 cycles after its FETCH.
- Enables are valid for the whole cycle; the datapath commits them at the closing rising edge.
- `op_code` is only decoded in EXEC/EXEC2. Its value in FETCH/DECODE is ignored, including X.
- No handshakes; the FSM free-runs.

## Configuration
- `PUNC_INSTR_COUNT_EN` defined:
  - Adds output `instr_count` [15:0], reset 0.
  - The count increments by 1 at each edge leaving EXEC to FETCH, leaving EXEC2, or leaving EXEC to HALT on TRAP.
  - It wraps from 16'hFFFF to 16'h0000 and is frozen in HALT.
- `PUNC_INSTR_COUNT_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then hold `op_code`=0001 (ADD):
  - `CNTRL_state` sequence 001, 010, 100, repeating.
  - `CNTRL_regfiles_w_en` and `CNTRL_status_w_en` high only in the 100 cycles.
  - `CNTRL_ir_w_en` and `CNTRL_pc_w_en` high in the 010 cycles.
- `op_code`=1010 (LDI):
  - Sequence 001, 010, 100 (`CNTRL_OC_LDI_first`=1), 100 (`CNTRL_OC_LDI_second`=1, `CNTRL_regfiles_w_en`=1), then 001.
  - 4-cycle period.
- `op_code`=1011 (STI): `CNTRL_memory_w_en`=1 for exactly one cycle per 3-cycle period; `CNTRL_regfiles_w_en` never 1.
- `op_code`=1111 (TRAP):
  - HALT entered after EXEC; `CNTRL_state`=000 and `halted`=1 held for 20+ cycles.
  - Asserting `rst` for 1 cycle returns `CNTRL_state` to 001.
- Assert `rst` during the EXEC2 of an LDI: the next cycle is FETCH and `CNTRL_OC_LDI_second` never pulses after reset.
- With `PUNC_INSTR_COUNT_EN`:
  - 5 ADDs followed by 1 LDI give `instr_count`=6.
  - Preloading the count near wrap and running 2 instructions from 16'hFFFF gives 16'h0001.

Source files
------------

// File: rtl/punc_control.sv
// punc_control: fetch/decode/execute sequencer for the PUnC LC3 datapath.
// State is registered; every CNTRL_* output is decoded from the current
// state and op_code, with reset forcing the FETCH view of the outputs.
// Optional feature: define PUNC_INSTR_COUNT_EN to add a retired-instruction
// counter on output instr_count.
module punc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  op_code,
    output logic [2:0]  CNTRL_state,
    output logic        CNTRL_ir_w_en,
    output logic        CNTRL_pc_w_en,
    output logic        CNTRL_regfiles_w_en,
    output logic        CNTRL_memory_w_en,
    output logic        CNTRL_status_w_en,
    output logic        CNTRL_OC_LDI_first,
    output logic        CNTRL_OC_LDI_second,
    output logic        halted
`ifdef PUNC_INSTR_COUNT_EN
    ,
    output logic [15:0] instr_count
`endif
);

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_EXEC2  = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    // Next-state selection; op_code is only consulted while in EXEC.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (op_code == OP_LDI)       state_next = S_EXEC2;
                else if (op_code == OP_TRAP) state_next = S_HALT;
                else                         state_next = S_FETCH;
            end
            S_EXEC2:  state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    // State register; reset wins from any state, including HALT and EXEC2.
    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    // Output decode; while rst is high the outputs look like an idle FETCH.
    always_comb begin
        CNTRL_state         = 3'b001;
        CNTRL_ir_w_en       = 1'b0;
        CNTRL_pc_w_en       = 1'b0;
        CNTRL_regfiles_w_en = 1'b0;
        CNTRL_memory_w_en   = 1'b0;
        CNTRL_status_w_en   = 1'b0;
        CNTRL_OC_LDI_first  = 1'b0;
        CNTRL_OC_LDI_second = 1'b0;
        halted              = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: CNTRL_state = 3'b001;
                S_DECODE: begin
                    CNTRL_state   = 3'b010;
                    CNTRL_ir_w_en = 1'b1;
                    CNTRL_pc_w_en = 1'b1;
                end
                S_EXEC: begin
                    CNTRL_state = 3'b100;
                    case (op_code)
                        OP_ADD, OP_AND, OP_NOT, OP_LD, OP_LDR: begin
                            CNTRL_regfiles_w_en = 1'b1;
                            CNTRL_status_w_en   = 1'b1;
                        end
                        OP_LEA: CNTRL_regfiles_w_en = 1'b1;
                        OP_JSR: begin
                            CNTRL_regfiles_w_en = 1'b1;
                            CNTRL_pc_w_en       = 1'b1;
                        end
                        OP_BR, OP_JMP:         CNTRL_pc_w_en      = 1'b1;
                        OP_ST, OP_STR, OP_STI: CNTRL_memory_w_en  = 1'b1;
                        OP_LDI:                CNTRL_OC_LDI_first = 1'b1;
                        default: ;  // TRAP, RTI, reserved: no enables
                    endcase
                end
                S_EXEC2: begin
                    CNTRL_state         = 3'b100;
                    CNTRL_OC_LDI_second = 1'b1;
                    CNTRL_regfiles_w_en = 1'b1;
                    CNTRL_status_w_en   = 1'b1;
                end
                S_HALT: begin
                    CNTRL_state = 3'b000;
                    halted      = 1'b1;
                end
                default: CNTRL_state = 3'b001;
            endcase
        end
    end

`ifdef PUNC_INSTR_COUNT_EN
    // Retire counter: bumps on every exit from EXEC/EXEC2 that ends an
    // instruction (LDI's first EXEC does not count), wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)
            instr_count <= 16'h0000;
        else if ((state == S_EXEC && op_code != OP_LDI) || state == S_EXEC2)
            instr_count <= instr_count + 16'h0001;
    end
`endif

endmodule
